// File: rtl/src_b_select_if.sv
// Decode-stage source-B select bus.
//   D_op    : decode-stage opcode (instr[31:26])
//   D_rs    : decode-stage second-source field (instr[20:16])
//   stall   : hold E_srcB
//   flush   : clear E_srcB to 0 (bubble)
//   d_srcB  : combinational source-B register index, 0 when B is not read
//   d_usesB : combinational, B is read and its index is non-zero
//   E_srcB  : execute-stage copy of d_srcB
// master drives the decode fields and controls; slave is the select block.
interface src_b_select_if #(
  parameter int unsigned OP_W  = 6,
  parameter int unsigned REG_W = 5
);
  logic [OP_W-1:0]  D_op;
  logic [REG_W-1:0] D_rs;
  logic             stall;
  logic             flush;
  logic [REG_W-1:0] d_srcB;
  logic             d_usesB;
  logic [REG_W-1:0] E_srcB;

  modport master (
    output D_op, D_rs, stall, flush,
    input  d_srcB, d_usesB, E_srcB
  );

  modport slave (
    input  D_op, D_rs, stall, flush,
    output d_srcB, d_usesB, E_srcB
  );
endinterface

// File: rtl/src_b_select.sv
// Source-B register select for the decode stage of the pipelined MIPS core.
// Returns the rt field as the second source register index for opcodes that read it,
// otherwise 0, and registers that index into the execute stage for hazard/forwarding use.
//
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : src_b_select_if.slave (D_op, D_rs, stall, flush in; d_srcB, d_usesB, E_srcB out)
//
// Build option:
//   SRCB_BRANCH_EN : when defined, BEQ and BNE also read source B.
module src_b_select #(
  parameter int unsigned OP_W  = 6,
  parameter int unsigned REG_W = 5
) (
  input logic            clk,
  input logic            rst,
  src_b_select_if.slave  bus
);

  localparam logic [OP_W-1:0] OpRop = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OpSw  = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OpSb  = OP_W'(6'b101000);
  localparam logic [OP_W-1:0] OpSh  = OP_W'(6'b101001);
`ifdef SRCB_BRANCH_EN
  localparam logic [OP_W-1:0] OpBeq = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OpBne = OP_W'(6'b000101);
`endif

  logic             reads_b;
  logic [REG_W-1:0] d_srcb;
  logic [REG_W-1:0] e_srcb_q;

  // Unlisted and undefined opcodes fall to the default so nothing X leaks downstream.
  always_comb begin
    reads_b = 1'b0;
    case (bus.D_op)
      OpRop, OpSw, OpSb, OpSh: reads_b = 1'b1;
`ifdef SRCB_BRANCH_EN
      OpBeq, OpBne:            reads_b = 1'b1;
`endif
      default:                 reads_b = 1'b0;
    endcase
  end

  always_comb begin
    d_srcb = '0;
    if (reads_b) begin
      d_srcb = bus.D_rs;
    end
  end

  // $0 is hardwired zero, so reading it can never create a hazard.
  assign bus.d_srcB  = d_srcb;
  assign bus.d_usesB = reads_b && (bus.D_rs != '0);

  // Priority: reset, then flush (bubble beats stall), then stall hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_srcb_q <= '0;
    end else if (bus.flush) begin
      e_srcb_q <= '0;
    end else if (!bus.stall) begin
      e_srcb_q <= d_srcb;
    end
  end

  assign bus.E_srcB = e_srcb_q;

endmodule

// File: tb/tb_src_b_select.sv
module tb_src_b_select;

  localparam logic [5:0] IROP = 6'b000000;
  localparam logic [5:0] IJ   = 6'b000010;
  localparam logic [5:0] IJAL = 6'b000011;
  localparam logic [5:0] IREG = 6'b000001;
  localparam logic [5:0] ILW  = 6'b100011;
  localparam logic [5:0] ISW  = 6'b101011;
  localparam logic [5:0] ISB  = 6'b101000;
  localparam logic [5:0] ISH  = 6'b101001;
  localparam logic [5:0] IBEQ = 6'b000100;
  localparam logic [5:0] IBNE = 6'b000101;

  typedef struct {
    int unsigned id;
    logic [4:0]  srcb;
    logic        usesb;
    logic [4:0]  e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t scb [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int unsigned step_id = 0;
  logic [4:0] model_e = '0;

  src_b_select_if #(.OP_W(6), .REG_W(5)) bus ();

  src_b_select #(.OP_W(6), .REG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: the set of opcodes that read a second register.
  function automatic bit reads_b(input logic [5:0] op);
    logic [5:0] set [$];
    set = {IROP, ISW, ISB, ISH};
`ifdef SRCB_BRANCH_EN
    set.push_back(IBEQ);
    set.push_back(IBNE);
`endif
    foreach (set[i]) begin
      if (set[i] == op) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input int unsigned id, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s (step %0d): got %0d required %0d", name, id, act, req);
  endtask

  // Advance one edge (updating the model from the inputs held at that edge), then drive
  // the next inputs and queue what the monitor should see this cycle.
  task automatic step(input logic [5:0] op, input logic [4:0] rs, input logic st,
                      input logic fl, input logic r);
    exp_t x;
    @(posedge clk);
    if (rst || bus.flush) model_e = '0;
    else if (!bus.stall) model_e = reads_b(bus.D_op) ? bus.D_rs : 5'd0;
    #1;
    rst       = r;
    bus.D_op  = op;
    bus.D_rs  = rs;
    bus.stall = st;
    bus.flush = fl;
    step_id++;
    x.id    = step_id;
    x.srcb  = reads_b(op) ? rs : 5'd0;
    x.usesb = reads_b(op) && (rs != 5'd0);
    x.e     = model_e;
    scb.push_back(x);
  endtask

  // Change D_rs mid-cycle and expect d_srcB to follow without any clock edge.
  task automatic mid_change(input logic [4:0] rs);
    @(negedge clk);
    #1;
    bus.D_rs = rs;
    #1;
    chk("d_srcB_nolatency", step_id, {27'd0, bus.d_srcB}, {27'd0, reads_b(bus.D_op) ? rs : 5'd0});
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (scb.size() != 0) begin
        x = scb.pop_front();
        chk("d_srcB", x.id, {27'd0, bus.d_srcB}, {27'd0, x.srcb});
        chk("d_usesB", x.id, {31'd0, bus.d_usesB}, {31'd0, x.usesb});
        chk("E_srcB", x.id, {27'd0, bus.E_srcB}, {27'd0, x.e});
      end
    end
  end

  initial begin : driver
    logic [5:0] pool [$];
    logic [5:0] op;
    pool = {IROP, IJ, IJAL, IREG, ILW, ISW, ISB, ISH, IBEQ, IBNE, 6'b001000, 6'b001111};
    rst = 1'b1;
    bus.D_op = IROP; bus.D_rs = 5'd0; bus.stall = 1'b0; bus.flush = 1'b0;

    step(IROP, 5'd3, 1'b0, 1'b0, 1'b1);       // still in reset: E_srcB must read 0
    step(IROP, 5'd19, 1'b0, 1'b0, 1'b0);
    step(IJ, 5'd16, 1'b0, 1'b0, 1'b0);        // E_srcB picks up 19 here
    step(ISW, 5'd16, 1'b0, 1'b0, 1'b0);
    mid_change(5'd18);
    step(IROP, 5'd11, 1'b1, 1'b0, 1'b0);      // stall from here on: E holds 18
    step(IROP, 5'd11, 1'b1, 1'b0, 1'b0);
    step(IROP, 5'd11, 1'b0, 1'b0, 1'b0);
    step(IROP, 5'd11, 1'b1, 1'b1, 1'b0);      // E becomes 11, then flush beats stall
    step(IROP, 5'd7, 1'b0, 1'b0, 1'b1);
    step(IROP, 5'd7, 1'b0, 1'b0, 1'b0);       // reset edge: E=0, d_srcB stays 7
    step(IROP, 5'd0, 1'b0, 1'b0, 1'b0);
    step(IBEQ, 5'd9, 1'b0, 1'b0, 1'b0);
    step(IBNE, 5'd21, 1'b0, 1'b0, 1'b0);
    step(ISB, 5'd31, 1'b0, 1'b0, 1'b0);
    step(ISH, 5'd1, 1'b0, 1'b0, 1'b0);
    step(ILW, 5'd5, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = pool[$urandom_range(0, pool.size() - 1)];
      step(op, 5'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 19) == 0));
    end
    step(IROP, 5'd2, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (scb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left required 0", scb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
